// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_rx_fifo: 8N1 UART receiver with mid-bit sampling and byte FIFO.   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int CLOCK_FREQ  = 100000000,
  parameter int BIT_RATE    = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       frame_error,
  output logic       overrun_error
);

  localparam int C_CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
  localparam int C_CNT_W        = (C_CLKS_PER_BIT > 1) ? $clog2(C_CLKS_PER_BIT) : 1;
  localparam int C_PTR_W        = $clog2(BUFFER_SIZE);

  localparam logic [C_CNT_W-1:0] C_HALF_M1 = C_CNT_W'(C_CLKS_PER_BIT / 2 - 1);
  localparam logic [C_CNT_W-1:0] C_BIT_M1  = C_CNT_W'(C_CLKS_PER_BIT - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
  localparam logic [C_PTR_W:0]   C_OCC_ONE = (C_PTR_W + 1)'(1);
  localparam logic [C_PTR_W:0]   C_OCC_MAX = (C_PTR_W + 1)'(BUFFER_SIZE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]         r_sync;
  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [C_CNT_W-1:0] r_baud_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_stop_valid;
  logic               r_stop_bit;
  logic [7:0]         r_mem [BUFFER_SIZE];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W:0]   r_count;
  logic [7:0]         r_rd_data;
  logic               r_frame_error;
  logic               r_overrun_error;

  logic w_rx_s;
  logic w_half_tick;
  logic w_bit_tick;
  logic w_cnt_clear;
  logic w_shift_en;
  logic w_stop_sample;
  logic w_pop;
  logic w_push_req;
  logic w_push;

  assign w_rx_s      = r_sync[1];
  assign w_half_tick = (r_baud_cnt == C_HALF_M1);
  assign w_bit_tick  = (r_baud_cnt == C_BIT_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_rx_s) w_state_next = S_START;
      S_START: if (w_half_tick) w_state_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_tick && (r_bit_cnt == 3'd7)) w_state_next = S_STOP;
      S_STOP:  if (w_bit_tick) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clear   = 1'b0;
    w_shift_en    = 1'b0;
    w_stop_sample = 1'b0;
    unique case (r_state)
      S_IDLE:  w_cnt_clear = 1'b1;
      S_START: w_cnt_clear = w_half_tick;
      S_DATA: begin
        w_cnt_clear = w_bit_tick;
        w_shift_en  = w_bit_tick;
      end
      S_STOP: begin
        w_cnt_clear   = w_bit_tick;
        w_stop_sample = w_bit_tick;
      end
      default: w_cnt_clear = 1'b1;
    endcase
  end

  // Stop result is registered so the FIFO push and error flags land one cycle after the stop sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_stop_valid <= 1'b0;
      r_stop_bit   <= 1'b0;
    end else begin
      r_baud_cnt   <= w_cnt_clear ? '0 : r_baud_cnt + C_CNT_ONE;
      if (r_state == S_IDLE) r_bit_cnt <= '0;
      else if (w_shift_en)   r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[7:1]};
      r_stop_valid <= w_stop_sample;
      if (w_stop_sample) r_stop_bit <= w_rx_s;
    end
  end

  assign w_pop      = rd_en && (r_count != '0);
  assign w_push_req = r_stop_valid && r_stop_bit;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_push     = w_push_req && ((r_count != C_OCC_MAX) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_rd_data       <= '0;
      r_frame_error   <= 1'b0;
      r_overrun_error <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_OCC_ONE;
        2'b01:   r_count <= r_count - C_OCC_ONE;
        default: r_count <= r_count;
      endcase
      r_frame_error   <= r_stop_valid && !r_stop_bit;
      r_overrun_error <= w_push_req && !w_push;
    end
  end

  assign rd_data       = r_rd_data;
  assign fifo_empty    = (r_count == '0);
  assign fifo_full     = (r_count == C_OCC_MAX);
  assign frame_error   = r_frame_error;
  assign overrun_error = r_overrun_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uart_rx_fifo: directed bench for uart_rx_fifo at 16 clocks per bit. |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_uart_rx_fifo;

  localparam int CF   = 16000000;
  localparam int BR   = 1000000;
  localparam int CPB  = CF / BR;
  localparam int HALF = CPB / 2;
  localparam int BS   = 16;
  // Cycles from the edge before rx falls to the edge that pushes / flags.
  localparam int LAT  = 4 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       frame_error;
  logic       overrun_error;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int failed = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_cyc = 0;
  int ov_cyc = 0;
  int fall_cyc = 0;
  int frame_e = 0;
  logic prev_empty = 1'b1;

  uart_rx_fifo #(
    .CLOCK_FREQ (CF),
    .BIT_RATE   (BR),
    .BUFFER_SIZE(BS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .frame_error  (frame_error),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_error) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (overrun_error) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (prev_empty && !fifo_empty) fall_cyc = cyc;
    prev_empty = fifo_empty;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a negedge; stop=0 forces a framing error.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    frame_e = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check(tag, {24'b0, rd_data}, {24'b0, exp});
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_data", {24'b0, rd_data}, 32'h00);
    check("rst_empty", {31'b0, fifo_empty}, 32'd1);
    check("rst_full", {31'b0, fifo_full}, 32'd0);
    check("rst_frame_err", {31'b0, frame_error}, 32'd0);
    check("rst_overrun", {31'b0, overrun_error}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with exact arrival time.
    send_byte(8'hA5, 1'b1);
    check("single_fall_time", fall_cyc, frame_e + LAT);
    check("single_not_empty", {31'b0, fifo_empty}, 32'd0);
    pop("single_data", 8'hA5);
    check("single_empty_after", {31'b0, fifo_empty}, 32'd1);
    check("single_no_errors", fe_cnt + ov_cnt, 32'd0);

    // Back-to-back frames without idle gap.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    pop("b2b_0", 8'h00);
    pop("b2b_1", 8'hFF);
    pop("b2b_2", 8'h55);
    check("b2b_no_frame_err", fe_cnt, 32'd0);

    // Start glitch shorter than half a bit.
    rx = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_empty", {31'b0, fifo_empty}, 32'd1);
    check("glitch_no_flags", fe_cnt + ov_cnt, 32'd0);

    // Framing error, then a good byte.
    send_byte(8'h3C, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("frame_err_count", fe_cnt, 32'd1);
    check("frame_err_time", fe_cyc, frame_e + LAT);
    check("frame_empty", {31'b0, fifo_empty}, 32'd1);
    send_byte(8'h81, 1'b1);
    pop("after_frame_data", 8'h81);
    check("after_frame_fe_count", fe_cnt, 32'd1);

    // Overrun: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i < BS + 1; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == BS - 2) check("ovr_not_full_15", {31'b0, fifo_full}, 32'd0);
      if (i == BS - 1) check("ovr_full_16", {31'b0, fifo_full}, 32'd1);
    end
    check("ovr_count", ov_cnt, 32'd1);
    check("ovr_time", ov_cyc, frame_e + LAT);
    check("ovr_still_full", {31'b0, fifo_full}, 32'd1);
    for (int i = 0; i < BS; i++) begin
      pop("ovr_pop", 8'(i));
      if (i == 0) check("ovr_full_drop", {31'b0, fifo_full}, 32'd0);
    end
    check("ovr_drained", {31'b0, fifo_empty}, 32'd1);

    // Refill across pointer wrap.
    for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i), 1'b1);
    for (int i = 0; i < 4; i++) pop("wrap_pop", 8'hB0 + 8'(i));
    check("wrap_empty", {31'b0, fifo_empty}, 32'd1);

    // Pop in the same cycle as a push while full.
    for (int i = 0; i < BS; i++) send_byte(8'h20 + 8'(i), 1'b1);
    check("pp_full_before", {31'b0, fifo_full}, 32'd1);
    fork
      send_byte(8'h40, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("pp_rd_data", {24'b0, rd_data}, 32'h20);
        check("pp_full_kept", {31'b0, fifo_full}, 32'd1);
      end
    join
    check("pp_no_overrun", ov_cnt, 32'd1);
    for (int i = 1; i < BS; i++) pop("pp_pop", 8'h20 + 8'(i));
    pop("pp_pop_last", 8'h40);
    check("pp_empty", {31'b0, fifo_empty}, 32'd1);

    // Reset during data bit 4 with one byte queued.
    send_byte(8'h77, 1'b1);
    check("rmf_queued", {31'b0, fifo_empty}, 32'd0);
    fork
      send_byte(8'hC3, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rmf_rd_data", {24'b0, rd_data}, 32'h00);
        check("rmf_empty", {31'b0, fifo_empty}, 32'd1);
        check("rmf_full", {31'b0, fifo_full}, 32'd0);
        check("rmf_flags", {30'b0, frame_error, overrun_error}, 32'd0);
      end
    join
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h5A, 1'b1);
    check("rmf_fresh_time", fall_cyc, frame_e + LAT);
    pop("rmf_fresh_data", 8'h5A);
    check("rmf_fresh_empty", {31'b0, fifo_empty}, 32'd1);
    check("final_fe_count", fe_cnt, 32'd1);
    check("final_ov_count", ov_cnt, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
